// File: rtl/ex_alu_unit.sv
// ex_alu_unit: 32-bit execute-stage ALU for the 5-stage MIPS pipeline.
// Arithmetic runs through a ripple chain of bit_adder full-adder cells;
// result and flags are registered (one cycle of latency, no back-pressure).
// Optional feature macro: ALU_OVERFLOW_EN. When defined, the overflow output
// reports signed overflow of ADD/ADC/SUB/SBB; when undefined it is tied to 0.

// Single full-adder cell of the ripple chain.
module bit_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic f,
  output logic cout
);
  assign f    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module ex_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucon,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             arith_ovf;
  logic             slt_bit;

  logic [WIDTH-1:0] result_next;
  logic             cout_next;
  logic             zero_next;

  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             zero_reg;
  logic             out_valid_reg;

  // Select B polarity and stage-0 carry-in for the adder chain per opcode.
  always_comb begin
    b_in     = b;
    carry_in = 1'b0;
    case (alucon)
      OP_ADD:  begin b_in = b;  carry_in = 1'b0; end
      OP_SUB:  begin b_in = ~b; carry_in = 1'b1; end
      OP_ADC:  begin b_in = b;  carry_in = cin;  end
      OP_SBB:  begin b_in = ~b; carry_in = cin;  end
      OP_SLT:  begin b_in = ~b; carry_in = 1'b1; end
      default: begin b_in = b;  carry_in = 1'b0; end
    endcase
  end

  assign carry[0] = carry_in;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      bit_adder u_cell (
        .a    (a[gi]),
        .b    (b_in[gi]),
        .cin  (carry[gi]),
        .f    (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign arith_ovf = carry[WIDTH] ^ carry[WIDTH-1];
  // Signed less-than from the subtract chain: sign of difference corrected by overflow.
  assign slt_bit   = sum[WIDTH-1] ^ arith_ovf;

  // Pick the result and carry for the current opcode; unknown opcodes yield 0.
  always_comb begin
    result_next = '0;
    cout_next   = 1'b0;
    case (alucon)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
        result_next = sum;
        cout_next   = carry[WIDTH];
      end
      OP_AND:  result_next = a & b;
      OP_OR:   result_next = a | b;
      OP_XOR:  result_next = a ^ b;
      OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, slt_bit};
      default: begin
        result_next = '0;
        cout_next   = 1'b0;
      end
    endcase
  end

  assign zero_next = ~|result_next;

  // Capture result and flags on a valid operation, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg    <= '0;
      cout_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        result_reg <= result_next;
        cout_reg   <= cout_next;
        zero_reg   <= zero_next;
      end
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic overflow_next;
  logic overflow_reg;

  // Overflow is meaningful only for the four adder-result opcodes.
  always_comb begin
    overflow_next = 1'b0;
    case (alucon)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: overflow_next = arith_ovf;
      default:                        overflow_next = 1'b0;
    endcase
  end

  // Overflow flag follows the same capture/hold/reset rules as the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (in_valid) begin
      overflow_reg <= overflow_next;
    end
  end

  assign overflow = overflow_reg;
`else
  assign overflow = 1'b0;
`endif

  assign result    = result_reg;
  assign cout      = cout_reg;
  assign zero      = zero_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed + randomized bench for ex_alu_unit with a scoreboard queue.
// Expected overflow depends on ALU_OVERFLOW_EN, matching the DUT build.
module tb_ex_alu_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alucon;
  logic        cin;
  logic [31:0] result;
  logic        cout;
  logic        zero;
  logic        overflow;
  logic        out_valid;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;
  logic [31:0] held_res;
  logic        held_co;
  logic        held_z;

  ex_alu_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alucon    (alucon),
    .cin       (cin),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: 33-bit arithmetic and native signed compare.
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op,
                       input logic c, output logic [31:0] r, output logic co, output logic ov);
    logic [32:0] s;
    logic [31:0] yy;
    r = '0; co = 1'b0; ov = 1'b0;
    yy = op[0] ? ~y : y;
    case (op)
      3'd0: s = {1'b0, x} + {1'b0, y};
      3'd1: s = {1'b0, x} + {1'b0, ~y} + 33'd1;
      3'd2: s = {1'b0, x} + {1'b0, y} + {32'd0, c};
      3'd3: s = {1'b0, x} + {1'b0, ~y} + {32'd0, c};
      default: s = '0;
    endcase
    if (op <= 3'd3) begin
      r  = s[31:0];
      co = s[32];
      ov = (x[31] == yy[31]) && (s[31] != x[31]);
    end else if (op == 3'd4) r = x & y;
    else if (op == 3'd5) r = x | y;
    else if (op == 3'd6) r = x ^ y;
    else r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
  endtask

  // Drive one op, push expectation, pop and compare after the capturing edge.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] op, input logic c,
                        input logic [31:0] er, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a = x; b = y; alucon = op; cin = c; in_valid = 1'b1;
    e.tag = tag; e.res = er; e.co = ec;
`ifdef ALU_OVERFLOW_EN
    e.ov = eo;
`else
    e.ov = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".result"},    result,    e.res);
    chk({e.tag, ".cout"},      {31'd0, cout},      {31'd0, e.co});
    chk({e.tag, ".zero"},      {31'd0, zero},      {31'd0, (e.res == 32'd0)});
    chk({e.tag, ".overflow"},  {31'd0, overflow},  {31'd0, e.ov});
    chk({e.tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    $display("op %s a=%h b=%h alucon=%0d cin=%0d -> result=%h cout=%0d zero=%0d ovf=%0d",
             e.tag, x, y, op, c, result, cout, zero, overflow);
    held_res = er; held_co = ec; held_z = (er == 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".result"},    result, 32'd0);
    chk({tag, ".cout"},      {31'd0, cout},      32'd0);
    chk({tag, ".zero"},      {31'd0, zero},      32'd0);
    chk({tag, ".overflow"},  {31'd0, overflow},  32'd0);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    $display("reset-check %s result=%h zero=%0d out_valid=%0d", tag, result, zero, out_valid);
  endtask

  initial begin
    logic [31:0] rx, ry, rr;
    logic [2:0]  rop;
    logic        rc, rco, rov;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alucon = '0; cin = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op("add_10_5",    32'd10, 32'd5,  3'b000, 1'b0, 32'd15, 1'b0, 1'b0);
    run_op("beq_equal",   32'd10, 32'd10, 3'b001, 1'b0, 32'd0, 1'b1, 1'b0);
    run_op("sub_5_10",    32'd5,  32'd10, 3'b001, 1'b0, 32'hFFFFFFFB, 1'b0, 1'b0);
    run_op("add_wrap",    32'hFFFFFFFF, 32'd1, 3'b000, 1'b0, 32'd0, 1'b1, 1'b0);
    run_op("adc_wrap",    32'hFFFFFFFF, 32'd1, 3'b010, 1'b1, 32'd1, 1'b1, 1'b0);
    run_op("sbb_borrow",  32'd7,  32'd3,  3'b011, 1'b0, 32'd3, 1'b1, 1'b0);
    run_op("and",         32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 1'b0, 32'hF000F000, 1'b0, 1'b0);
    run_op("or",          32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b0);
    run_op("xor",         32'hF0F0F0F0, 32'hFF00FF00, 3'b110, 1'b0, 32'h0FF00FF0, 1'b0, 1'b0);
    run_op("slt_neg",     32'hFFFFFFFF, 32'd1, 3'b111, 1'b0, 32'd1, 1'b0, 1'b0);
    run_op("slt_pos",     32'd1, 32'hFFFFFFFF, 3'b111, 1'b0, 32'd0, 1'b0, 1'b0);
    run_op("slt_ovf",     32'h80000000, 32'd1, 3'b111, 1'b0, 32'd1, 1'b0, 1'b0);
    run_op("add_ovf",     32'h7FFFFFFF, 32'd1, 3'b000, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_ovf",     32'h80000000, 32'd1, 3'b001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      rx = $urandom; ry = $urandom; rop = 3'($urandom_range(0, 7)); rc = 1'($urandom_range(0, 1));
      if (i % 6 == 0) ry = rx;
      model(rx, ry, rop, rc, rr, rco, rov);
      run_op($sformatf("rand%0d", i), rx, ry, rop, rc, rr, rco, rov);
    end

    // Hold: no valid input for three cycles, outputs keep the last capture.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; alucon = 3'b101;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d.result", i), result, held_res);
      chk($sformatf("hold%0d.cout", i), {31'd0, cout}, {31'd0, held_co});
      chk($sformatf("hold%0d.zero", i), {31'd0, zero}, {31'd0, held_z});
      chk($sformatf("hold%0d.out_valid", i), {31'd0, out_valid}, 32'd0);
      $display("hold %0d result=%h out_valid=%0d", i, result, out_valid);
    end

    // Asynchronous reset between edges clears outputs before the next edge.
    run_op("pre_rst", 32'hFFFFFFFF, 32'd1, 3'b000, 1'b0, 32'd0, 1'b1, 1'b0);
    run_op("pre_rst2", 32'h7FFFFFFF, 32'd1, 3'b000, 1'b0, 32'h80000000, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");

    // A valid op presented during reset is discarded.
    in_valid = 1'b1; a = 32'd10; b = 32'd5; alucon = 3'b000;
    @(posedge clk);
    #1;
    chk_all_zero("rst_discard");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("post_rst_idle");

    run_op("recover_add", 32'd10, 32'd5, 3'b000, 1'b0, 32'd15, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- 32-bit execute-stage ALU for the 5-stage MIPS pipeline.
- Arithmetic is built from 32 chained bit_adder full-adder cells forming a ripple-carry adder.
- Result and flags are registered: one cycle of latency.
- The zero flag drives beq resolution. Branch compare uses alucon=001 (SUB); the branch is taken when zero=1.

Parameters:
- WIDTH, 32, datapath width. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high. Clears all registered outputs.
- in_valid  input  1  operands and opcode are valid this cycle.
- a  input  32  operand A (forwarding-mux output).
- b  input  32  operand B.
- alucon  input  3  operation select.
- cin  input  1  carry/borrow-in. Used only by ADC/SBB.
- result  output  32  registered result.
- cout  output  1  registered carry-out of adder chain. 0 for logic ops and SLT.
- zero  output  1  registered, 1 when result==0.
- overflow  output  1  registered signed overflow; see Optional Feature.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- bit_adder cell: F = A^B^cin; cout = (A&B)|(A&cin)|(B&cin). Purely combinational.
- Chain: 32 cells; stage i carry-out feeds stage i+1. Stage 0 carry-in and B-inversion are per opcode. Chain cout = carry out of bit 31.
- alucon decode:
  - 000 ADD: a+b, carry-in 0.
  - 001 SUB: a+~b, carry-in 1. cout=1 means no borrow (a>=b unsigned).
  - 010 ADC: a+b+cin.
  - 011 SBB: a+~b+cin. cin=1 means no borrow in.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 SLT: result = {31'b0, signed(a)<signed(b)}, computed from the SUB chain as sum[31]^ovf.
- All arithmetic is modulo 2^32; wrap-around is silent.
- Capture: on rising clk with in_valid=1, the following are loaded simultaneously from the combinational values:
  - result, cout, zero (=~|next_result), overflow;
  - out_valid<=1.
- Hold: on rising clk with in_valid=0, result/cout/zero/overflow hold their values; out_valid<=0.
- Reset: rst=1 forces result=0, cout=0, zero=0, overflow=0, out_valid=0 immediately, independent of clk.
  - zero is 0 during reset because no valid result exists.
  - The first capture is at the first rising edge after rst deasserts.
- rst asserted mid-operation: the in-flight capture is discarded; outputs are 0 until a new in_valid capture.
- Unknown/X alucon: result forced to 0, cout=0. zero is still computed, giving 1.
- Latency is exactly 1 cycle. There is no back-pressure; a new operation may be presented every cycle.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined: overflow = signed overflow of ADD/ADC/SUB/SBB, i.e. carry into bit31 XOR carry out of bit31. overflow=0 for logic ops and SLT.
- Undefined: overflow is tied to constant 0 (port remains) and no overflow logic is synthesized. SLT still uses internal overflow.

Test Plan:
- Reset then ADD: rst pulse; a=10, b=5, alucon=000, in_valid=1 -> next edge: result=15, cout=0, zero=0, out_valid=1.
- beq compare: a=10, b=10, alucon=001 -> result=0, zero=1, cout=1. Then a=5, b=10, SUB -> result=0xFFFFFFFB, zero=0, cout=0.
- Carry wrap: a=0xFFFFFFFF, b=1, ADD -> result=0, cout=1, zero=1. Same with ADC and cin=1 -> result=1, cout=1.
- Logic/SLT: a=0xF0F0F0F0, b=0xFF00FF00 -> AND=0xF000F000, OR=0xFFF0FFF0, XOR=0x0FF00FF0. SLT with a=0xFFFFFFFF (-1), b=1 -> result=1.
- Overflow: a=0x7FFFFFFF, b=1, ADD -> result=0x80000000; overflow=1 with ALU_OVERFLOW_EN, 0 without.
- Hold/async reset: in_valid=0 for 3 cycles -> outputs hold, out_valid=0. Assert rst between edges -> all outputs 0 immediately, before the next clk edge.
